shift_left_logical_seq_8bit: RTL and testbench



---
 rtl/shift_left_logical_seq_8bit.sv | 60 ++++++
 tb/tb_shift_left_logical_seq_8bit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/shift_left_logical_seq_8bit.sv
// shift_left_logical_seq_8bit: sequential logical left shifter, one bit per clock, start/busy/done handshake
module shift_left_logical_seq_8bit #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [AMT_W-1:0] amount,
   output logic [WIDTH-1:0] f,
   output logic             cout,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] f_q, f_d;
   logic             cout_q, cout_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [AMT_W-1:0] amt_c;
   assign amt_c = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;
   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      if (state_q == SHIFT) begin
         f_d     = {f_q[WIDTH-2:0], 1'b0};
         cout_d  = f_q[WIDTH-1];
         cnt_d   = cnt_q - AMT_W'(1);
         state_d = (cnt_q == AMT_W'(1)) ? DONE : SHIFT;
      end else if (start) begin
         // accepted from both IDLE and DONE, so back-to-back ops skip IDLE
         f_d     = x;
         cnt_d   = amt_c;
         cout_d  = 1'b0;
         state_d = (amt_c != '0) ? SHIFT : DONE;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         f_q     <= '0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end
   assign f    = f_q;
   assign cout = cout_q;
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
endmodule

// File: tb/tb_shift_left_logical_seq_8bit.sv
// tb_shift_left_logical_seq_8bit: directed-vector bench for the sequential left shifter
module tb_shift_left_logical_seq_8bit;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] x = '0;
   logic [3:0] amount = '0;
   logic [7:0] f;
   logic       cout, busy, done;
   int total = 0, bad = 0;

   shift_left_logical_seq_8bit #(.WIDTH(8), .AMT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .x(x), .amount(amount),
      .f(f), .cout(cout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Launch one op and return at the negedge where done is first seen.
   // done_k counts negedges after the start edge; -1 means done never came.
   task automatic run_op(input logic [7:0] xv, input logic [3:0] av, output int busy_n, output int done_k);
      @(negedge clk);
      x = xv; amount = av; start = 1'b1;
      @(negedge clk);
      start = 1'b0; x = ~xv; amount = 4'd0;
      busy_n = 0; done_k = -1;
      for (int k = 0; k < 40; k++) begin
         if (done) begin done_k = k; break; end
         if (busy) busy_n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (f !== 8'h00) begin bad++; $display("FAIL reset_f got=%h exp=00", f); end
      total++; if ({cout, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {cout, busy, done}); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if ({f, cout, busy, done} !== 11'd0) begin bad++; $display("FAIL idle_hold got=%h exp=0", {f, cout, busy, done}); end
   endtask

   task automatic test_single();
      int b, d;
      run_op(8'b10001110, 4'd1, b, d);
      total++; if (b !== 1) begin bad++; $display("FAIL t1_busy got=%0d exp=1", b); end
      total++; if (d !== 1) begin bad++; $display("FAIL t1_done_lat got=%0d exp=1", d); end
      total++; if (f !== 8'b00011100) begin bad++; $display("FAIL t1_f got=%b exp=00011100", f); end
      total++; if (cout !== 1'b1) begin bad++; $display("FAIL t1_cout got=%b exp=1", cout); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_done_pulse got=%b exp=0", done); end
      total++; if ({f, cout} !== {8'b00011100, 1'b1}) begin bad++; $display("FAIL t1_hold got=%h exp=039", {f, cout}); end
   endtask

   task automatic test_steps();
      logic [7:0] exp_f [4] = '{8'b11001101, 8'b10011010, 8'b00110100, 8'b01101000};
      logic       exp_c [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int dones = 0;
      @(negedge clk);
      x = 8'b11001101; amount = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         total++; if (f !== exp_f[k] || cout !== exp_c[k]) begin bad++; $display("FAIL t2_step%0d got=%b/%b exp=%b/%b", k, f, cout, exp_f[k], exp_c[k]); end
         total++; if (busy !== (k < 3)) begin bad++; $display("FAIL t2_busy%0d got=%b exp=%b", k, busy, k < 3); end
         if (done) dones++;
         @(negedge clk);
      end
      if (done) dones++;
      total++; if (dones !== 1) begin bad++; $display("FAIL t2_done_count got=%0d exp=1", dones); end
   endtask

   task automatic test_zero();
      int b, d;
      run_op(8'b11111101, 4'd0, b, d);
      total++; if (b !== 0 || d !== 0) begin bad++; $display("FAIL t3_lat got=busy%0d/done%0d exp=0/0", b, d); end
      total++; if (f !== 8'b11111101 || cout !== 1'b0) begin bad++; $display("FAIL t3_f got=%b/%b exp=11111101/0", f, cout); end
   endtask

   task automatic test_clamp();
      int b, d;
      logic [3:0] amts [2] = '{4'd8, 4'd12};
      for (int i = 0; i < 2; i++) begin
         run_op(8'b10001111, amts[i], b, d);
         total++; if (b !== 8 || d !== 8) begin bad++; $display("FAIL t4_lat_amt%0d got=busy%0d/done%0d exp=8/8", amts[i], b, d); end
         total++; if (f !== 8'h00 || cout !== 1'b1) begin bad++; $display("FAIL t4_f_amt%0d got=%h/%b exp=00/1", amts[i], f, cout); end
      end
   endtask

   task automatic test_ignore_start_and_reset();
      int d = -1, seen = 0;
      @(negedge clk);
      x = 8'hFF; amount = 4'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k == 1) begin start = 1'b1; x = 8'h00; amount = 4'd1; end
         if (k == 2) start = 1'b0;
         if (done) begin d = k; break; end
         @(negedge clk);
      end
      total++; if (d !== 5) begin bad++; $display("FAIL t5_done_lat got=%0d exp=5", d); end
      total++; if (f !== 8'hE0 || cout !== 1'b1) begin bad++; $display("FAIL t5_f got=%h/%b exp=e0/1", f, cout); end
      @(negedge clk);
      x = 8'hFF; amount = 4'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (f !== 8'hFC || busy !== 1'b1) begin bad++; $display("FAIL t5_pre_rst got=%h/%b exp=fc/1", f, busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if ({f, cout, busy, done} !== 11'd0) begin bad++; $display("FAIL t5_rst got=%h exp=0", {f, cout, busy, done}); end
      repeat (10) begin
         if (done || busy || f !== 8'h00) seen++;
         @(negedge clk);
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL t5_after_rst got=%0d exp=0", seen); end
   endtask

   task automatic test_back_to_back();
      int b, d, dones = 1;
      run_op(8'h03, 4'd2, b, d);
      total++; if (d !== 2 || f !== 8'h0C || cout !== 1'b0) begin bad++; $display("FAIL t6_first got=%0d/%h/%b exp=2/0c/0", d, f, cout); end
      x = 8'h81; amount = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++; if (busy !== 1'b1 || done !== 1'b0 || f !== 8'h81) begin bad++; $display("FAIL t6_no_idle got=%b/%b/%h exp=1/0/81", busy, done, f); end
      @(negedge clk);
      if (done) dones++;
      total++; if (f !== 8'h02 || cout !== 1'b1) begin bad++; $display("FAIL t6_second got=%h/%b exp=02/1", f, cout); end
      @(negedge clk);
      if (done) dones++;
      total++; if (dones !== 2) begin bad++; $display("FAIL t6_done_count got=%0d exp=2", dones); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_steps();
      test_zero();
      test_clamp();
      test_ignore_start_and_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
